// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage (main + skid) with registered in_ready, flush,
// bubble insertion when empty, and a saturating count of bubble cycles.
module pipe_stage_skid #(
  parameter int                DATA_W    = 128,
  parameter int                PC_W      = 32,
  parameter logic [PC_W-1:0]   PC_RST    = 'h0000_3000,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [1:0]        occupancy,
  output logic [15:0]       bubble_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                ready_q, ready_d;
  logic [15:0]         bubble_q;
  logic                head_valid, accept, consume;

  // Handshake: a beat moves on an edge where valid and ready are both 1 and
  // flush is 0; ready never depends combinationally on the same-side valid
  // or on out_ready.
  assign head_valid = (state_q != ST_EMPTY);
  assign in_ready   = ready_q & reset;
  assign accept     = in_valid & in_ready & ~flush;
  assign consume    = head_valid & out_ready & ~flush;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_data_d  = main_data_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_data_d  = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
          main_data_d  = in_data;
          state_d      = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && consume) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
          main_data_d  = in_data;
        end else if (accept) begin
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
          skid_data_d  = in_data;
          state_d      = ST_SKID;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (consume) begin
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
          main_data_d  = skid_data_q;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          skid_data_d  = '0;
          state_d      = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything, including a beat arriving in the same cycle.
    if (flush) begin
      state_d      = ST_EMPTY;
      main_instr_d = '0;
      main_pc_d    = '0;
      main_data_d  = '0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      skid_data_d  = '0;
    end
  end

  assign ready_d = (state_d != ST_SKID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_data_q  <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
      bubble_q     <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_data_q  <= main_data_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
      if (!head_valid && (bubble_q != 16'hFFFF)) begin
        bubble_q <= bubble_q + 16'd1;
      end
    end
  end

  // An empty stage presents a NOP bubble rather than stale register contents.
  assign out_valid  = head_valid;
  assign out_instr  = head_valid ? main_instr_q : NOP_INSTR;
  assign out_pc     = head_valid ? main_pc_q    : PC_RST;
  assign out_data   = head_valid ? main_data_q  : '0;
  assign out_rs     = out_instr[25:21];
  assign out_rt     = out_instr[20:16];
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_q;
  assign state_dbg  = state_q;

endmodule
